// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and FSM state type for the sequential ALU
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_ADC   = 4'b0011;
    localparam logic [3:0] OP_SBB   = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_NOT   = 4'b0111;
    localparam logic [3:0] OP_SHL1  = 4'b1000;
    localparam logic [3:0] OP_SHR1  = 4'b1001;
    localparam logic [3:0] OP_ROL1  = 4'b1010;
    localparam logic [3:0] OP_INC   = 4'b1011;
    localparam logic [3:0] OP_DEC   = 4'b1100;
    localparam logic [3:0] OP_CMP   = 4'b1101;
    localparam logic [3:0] OP_MUL   = 4'b1110;
    localparam logic [3:0] OP_PASSB = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operation/result handshake bundle between register file, ALU and writeback
interface alu_seq_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, result, cout, zero, neg, ovf, busy
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, result, cout, zero, neg, ovf, busy
    );
endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add multiplier, one multiplier bit per cycle
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int CW = $clog2(WIDTH);

    logic               active_q, active_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_next;

    // product_o is the accumulator after this cycle's step, so the final
    // iteration's sum is visible while done_o is high
    assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = active_q && (cnt_q == CW'(WIDTH - 1));
    assign product_o = acc_next;

    always_comb begin
        active_d = active_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            active_d = 1'b1;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (active_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done_o) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with flags, valid/ready handshake and iterative multiply
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic               accept, is_mul, mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     ax, bx, arith;
    logic [WIDTH-1:0]   bop, core_res, core_flag;
    logic               core_c, core_v, add_cls, sub_cls, is_cmp;

    assign bus.in_ready  = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign is_mul        = (bus.op == OPW'(OP_MUL));
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = (state_q == ST_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (bus.a),
        .b_i       (bus.b),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // bop is the effective second operand, used for signed-overflow detection
    always_comb begin
        ax        = {1'b0, bus.a};
        bx        = {1'b0, bus.b};
        arith     = '0;
        bop       = bus.b;
        core_res  = '0;
        core_c    = 1'b0;
        add_cls   = 1'b0;
        sub_cls   = 1'b0;
        is_cmp    = 1'b0;
        case (bus.op)
            OPW'(OP_AND):   core_res = bus.a & bus.b;
            OPW'(OP_SUB):   begin arith = ax - bx; sub_cls = 1'b1; end
            OPW'(OP_ADD):   begin arith = ax + bx; add_cls = 1'b1; end
            OPW'(OP_ADC):   begin arith = ax + bx + (WIDTH+1)'(bus.cin); add_cls = 1'b1; end
            OPW'(OP_SBB):   begin arith = ax - bx - (WIDTH+1)'(bus.cin); sub_cls = 1'b1; end
            OPW'(OP_XOR):   core_res = bus.a ^ bus.b;
            OPW'(OP_OR):    core_res = bus.a | bus.b;
            OPW'(OP_NOT):   core_res = ~bus.a;
            OPW'(OP_SHL1):  begin core_res = {bus.a[MSB-1:0], 1'b0}; core_c = bus.a[MSB]; end
            OPW'(OP_SHR1):  begin core_res = {1'b0, bus.a[MSB:1]}; core_c = bus.a[0]; end
            OPW'(OP_ROL1):  begin core_res = {bus.a[MSB-1:0], bus.a[MSB]}; core_c = bus.a[MSB]; end
            OPW'(OP_INC):   begin arith = ax + (WIDTH+1)'(1); bop = WIDTH'(1); add_cls = 1'b1; end
            OPW'(OP_DEC):   begin arith = ax - (WIDTH+1)'(1); bop = WIDTH'(1); sub_cls = 1'b1; end
            OPW'(OP_CMP):   begin arith = ax - bx; sub_cls = 1'b1; is_cmp = 1'b1; end
            OPW'(OP_PASSB): core_res = bus.b;
            default:        core_res = '0;
        endcase
        if (add_cls || sub_cls) begin
            core_res = arith[MSB:0];
            core_c   = arith[WIDTH];
        end
        core_v = add_cls ? ((bus.a[MSB] == bop[MSB]) && (core_res[MSB] != bus.a[MSB])) :
                 sub_cls ? ((bus.a[MSB] != bop[MSB]) && (core_res[MSB] != bus.a[MSB])) : 1'b0;
        // CMP reports flags of a-b but hands a through unchanged
        core_flag = core_res;
        if (is_cmp) begin
            core_res = bus.a;
        end
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        mul_start   = 1'b0;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                    end else begin
                        result_d    = core_res;
                        cout_d      = core_c;
                        zero_d      = (core_flag == '0);
                        neg_d       = core_flag[MSB];
                        ovf_d       = core_v;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    result_d    = mul_product[MSB:0];
                    cout_d      = |mul_product[2*WIDTH-1:WIDTH];
                    zero_d      = (mul_product[MSB:0] == '0);
                    neg_d       = mul_product[MSB];
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq at WIDTH=8
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8), .OPW(4)) bus ();
    alu_seq #(.WIDTH(8), .OPW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t       sb_q[$];
    exp_t       mon_e, mon_got;
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    logic [7:0] corners [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic ci);
        int ua, ub, sa, sb, ic, t, st;
        logic [7:0] r, f;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        ic = ci ? 1 : 0;
        t = 0; st = 0; c = 1'b0; r = 8'h00;
        case (op)
            OP_AND:   r = a & b;
            OP_SUB:   begin t = ua - ub;      c = (ua < ub);      st = sa - sb;      r = t[7:0]; end
            OP_ADD:   begin t = ua + ub;      c = (t > 255);      st = sa + sb;      r = t[7:0]; end
            OP_ADC:   begin t = ua + ub + ic; c = (t > 255);      st = sa + sb + ic; r = t[7:0]; end
            OP_SBB:   begin t = ua - ub - ic; c = (ua < ub + ic); st = sa - sb - ic; r = t[7:0]; end
            OP_XOR:   r = a ^ b;
            OP_OR:    r = a | b;
            OP_NOT:   r = ~a;
            OP_SHL1:  begin r = {a[6:0], 1'b0}; c = a[7]; end
            OP_SHR1:  begin r = {1'b0, a[7:1]}; c = a[0]; end
            OP_ROL1:  begin r = {a[6:0], a[7]}; c = a[7]; end
            OP_INC:   begin t = ua + 1; c = (t > 255); st = sa + 1; r = t[7:0]; end
            OP_DEC:   begin t = ua - 1; c = (ua < 1);  st = sa - 1; r = t[7:0]; end
            OP_CMP:   begin t = ua - ub; c = (ua < ub); st = sa - sb; r = a; end
            OP_MUL:   begin t = ua * ub; r = t[7:0]; c = ((t >> 8) != 0); end
            default:  r = b;
        endcase
        v = (st > 127) || (st < -128);
        f = (op == OP_CMP) ? t[7:0] : r;
        return {r, c, (f == 8'h00), f[7], v};
    endfunction

    // scoreboard: every result transfer is matched against the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            mon_got = {bus.result, bus.cout, bus.zero, bus.neg, bus.ovf};
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got result %h flags %b, required no output", bus.result, mon_got[3:0]);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_got !== mon_e) begin
                    miscompares++;
                    $display("FAIL sb_result: got res=%h c%b z%b n%b v%b, required res=%h c%b z%b n%b v%b",
                             mon_got.res, mon_got.c, mon_got.z, mon_got.n, mon_got.v,
                             mon_e.res, mon_e.c, mon_e.z, mon_e.n, mon_e.v);
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ci,
                        output int waits);
        bus.op = op; bus.a = a; bus.b = b; bus.cin = ci; bus.in_valid = 1'b1;
        waits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back(model(op, a, b, ci));
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                acc_cyc = cyc;
                return;
            end
            waits++;
            @(posedge clk); #1;
        end
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: op %h not accepted after %0d cycles, required acceptance", op, waits);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.op = 4'h0; bus.a = 8'h00; bus.b = 8'h00; bus.cin = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
        vectors++; if (bus.result !== 8'h00) begin miscompares++; $display("FAIL reset_result: got %h, required 00", bus.result); end
        vectors++; if ({bus.cout, bus.zero, bus.neg, bus.ovf} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b, required 0000", {bus.cout, bus.zero, bus.neg, bus.ovf}); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_latency();
        int w;
        bus.out_ready = 1'b1;
        send(OP_ADD, 8'hF0, 8'h20, 1'b0, w);
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL add_latency: got out_valid %b, required 1", bus.out_valid); end
        vectors++; if ({bus.result, bus.cout, bus.zero, bus.ovf} !== {8'h10, 3'b100}) begin miscompares++; $display("FAIL add_f0_20: got %h c%b z%b v%b, required 10 c1 z0 v0", bus.result, bus.cout, bus.zero, bus.ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_sub_cmp();
        int w;
        send(OP_SUB, 8'h80, 8'h01, 1'b0, w);
        @(negedge clk);
        vectors++; if ({bus.result, bus.cout, bus.ovf} !== {8'h7F, 2'b01}) begin miscompares++; $display("FAIL sub_80_01: got %h c%b v%b, required 7f c0 v1", bus.result, bus.cout, bus.ovf); end
        @(posedge clk); #1;
        send(OP_CMP, 8'h05, 8'h05, 1'b0, w);
        @(negedge clk);
        vectors++; if ({bus.result, bus.zero, bus.cout} !== {8'h05, 2'b10}) begin miscompares++; $display("FAIL cmp_eq: got %h z%b c%b, required 05 z1 c0", bus.result, bus.zero, bus.cout); end
        @(posedge clk); #1;
    endtask

    task automatic test_all_ops();
        int w;
        for (int o = 0; o < 16; o++) begin
            if (4'(o) == OP_MUL) continue;
            for (int k = 0; k < 4; k++) begin
                send(4'(o), corners[k], corners[3-k], k[0], w);
            end
            send(4'(o), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), w);
        end
    endtask

    task automatic test_back_to_back();
        int w0, w1, w2, c0, c1;
        bus.out_ready = 1'b1;
        send(OP_ADD, 8'h11, 8'h22, 1'b0, w0); c0 = acc_cyc;
        send(OP_XOR, 8'h0F, 8'hFF, 1'b0, w1); c1 = acc_cyc;
        send(OP_SHL1, 8'h81, 8'h00, 1'b0, w2);
        vectors++; if ((c1 - c0) != 1 || (acc_cyc - c1) != 1 || (w1 + w2) != 0) begin miscompares++; $display("FAIL b2b_throughput: got gaps %0d/%0d waits %0d, required 1/1 waits 0", c1 - c0, acc_cyc - c1, w1 + w2); end
        @(negedge clk);
        vectors++; if ({bus.out_valid, bus.result, bus.cout} !== {1'b1, 8'h02, 1'b1}) begin miscompares++; $display("FAIL shl_81: got v%b %h c%b, required v1 02 c1", bus.out_valid, bus.result, bus.cout); end
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        int w;
        bus.out_ready = 1'b0;
        send(OP_ADD, 8'h12, 8'h34, 1'b0, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if ({bus.out_valid, bus.result, bus.cout, bus.zero, bus.in_ready} !== {1'b1, 8'h46, 3'b000}) begin miscompares++; $display("FAIL hold_%0d: got v%b %h c%b z%b rdy%b, required v1 46 c0 z0 rdy0", i, bus.out_valid, bus.result, bus.cout, bus.zero, bus.in_ready); end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        send(OP_SUB, 8'h50, 8'h10, 1'b0, w);
        vectors++; if (w != 0) begin miscompares++; $display("FAIL hold_release: got %0d wait cycles, required 0", w); end
        @(negedge clk);
        vectors++; if ({bus.out_valid, bus.result} !== {1'b1, 8'h40}) begin miscompares++; $display("FAIL hold_next: got v%b %h, required v1 40", bus.out_valid, bus.result); end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int w;
        bus.out_ready = 1'b1;
        send(OP_MUL, 8'h10, 8'h20, 1'b0, w);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            vectors++; if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b100) begin miscompares++; $display("FAIL mul_busy_%0d: got busy%b rdy%b ov%b, required busy1 rdy0 ov0", i, bus.busy, bus.in_ready, bus.out_valid); end
        end
        @(negedge clk);
        vectors++; if ({bus.out_valid, bus.busy, bus.result, bus.cout, bus.zero} !== {2'b10, 8'h00, 2'b11}) begin miscompares++; $display("FAIL mul_10_20: got ov%b busy%b %h c%b z%b, required ov1 busy0 00 c1 z1", bus.out_valid, bus.busy, bus.result, bus.cout, bus.zero); end
        @(posedge clk); #1;
        send(OP_MUL, 8'h0B, 8'h0D, 1'b0, w);
        send(OP_MUL, 8'hFF, 8'hFF, 1'b1, w);
        send(OP_MUL, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, w);
        send(OP_ADD, 8'h7F, 8'h01, 1'b0, w);
    endtask

    task automatic test_reset_mid_mul();
        int w;
        bus.out_ready = 1'b1;
        send(OP_MUL, 8'h33, 8'h44, 1'b0, w);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        vectors++; if ({bus.in_ready, bus.busy, bus.out_valid, bus.result, bus.cout, bus.zero} !== {3'b100, 8'h00, 2'b00}) begin miscompares++; $display("FAIL reset_mid_mul: got rdy%b busy%b ov%b %h c%b z%b, required rdy1 busy0 ov0 00 c0 z0", bus.in_ready, bus.busy, bus.out_valid, bus.result, bus.cout, bus.zero); end
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(OP_ADD, 8'h01, 8'h01, 1'b0, w);
        @(negedge clk);
        vectors++; if ({bus.out_valid, bus.result} !== {1'b1, 8'h02}) begin miscompares++; $display("FAIL after_reset_add: got v%b %h, required v1 02", bus.out_valid, bus.result); end
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add_latency();
        test_sub_cmp();
        test_all_ops();
        test_back_to_back();
        test_hold();
        test_mul();
        test_reset_mid_mul();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        vectors++; if (sb_q.size() != 0) begin miscompares++; $display("FAIL sb_drain: got %0d pending results, required 0", sb_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
